// File: rtl/xgmii_gmii_tx_pkg.sv
// xgmii_gmii_tx_pkg: xgmii control octets and converter FSM states
package xgmii_gmii_tx_pkg;
  localparam logic [7:0] START_OCT = 8'hFB;
  localparam logic [7:0] TERM_OCT  = 8'hFD;
  localparam logic [7:0] ERROR_OCT = 8'hFE;
  localparam logic [7:0] IDLE_OCT  = 8'h07;
  localparam logic [7:0] PRE_FILL  = 8'h55;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_ABORT} state_t;
endpackage

// File: rtl/xgmii_lane_sel.sv
// xgmii_lane_sel: word hold register and lane/nibble walker; emits current {ctl, oct, nib_hi} plus underrun, early-strobe and mode-change flags
module xgmii_lane_sel (
  input  logic        clk,
  input  logic        rst,
  input  logic        mii_mode_i,
  input  logic        clk_en_i,
  input  logic [63:0] xd_i,
  input  logic [7:0]  xc_i,
  output logic        ctl,
  output logic [7:0]  oct,
  output logic        nib_hi,
  output logic        mii,
  output logic        underrun,
  output logic        early,
  output logic        mode_chg
);
  import xgmii_gmii_tx_pkg::*;
  logic [63:0] hold_d;
  logic [7:0]  hold_c;
  logic [4:0]  cnt;
  logic        mode;
  logic [4:0]  last;
  logic [2:0]  lane;
  assign last     = mode ? 5'd16 : 5'd8;
  assign underrun = !clk_en_i && cnt == last;
  assign early    = clk_en_i && cnt != last;
  assign mode_chg = clk_en_i && mii_mode_i != mode;
  assign mii      = clk_en_i ? mii_mode_i : mode;
  assign lane     = mode ? cnt[3:1] : cnt[2:0];
  assign nib_hi   = !clk_en_i && mode && cnt[0];
  assign ctl      = clk_en_i ? xc_i[0] : hold_c[lane];
  assign oct      = clk_en_i ? xd_i[7:0] : hold_d[{lane, 3'b000} +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      hold_d <= {8{IDLE_OCT}};
      hold_c <= 8'hFF;
      cnt    <= 5'd8;
      mode   <= 1'b0;
    end else if (clk_en_i) begin
      hold_d <= xd_i;
      hold_c <= xc_i;
      cnt    <= 5'd1;
      mode   <= mii_mode_i;
    end else if (cnt != last) begin
      cnt <= cnt + 5'd1;
    end
endmodule

// File: rtl/xgmii_gmii_tx.sv
// xgmii_gmii_tx: xgmii-like 64-bit words to GMII octets / MII nibbles (clk, rst, mii_mode_i, clk_en_i, xd_i, xc_i -> en_o, er_o, d_o, sfd_o, frm_err_o)
module xgmii_gmii_tx #(
  parameter logic [7:0] SFD_OCT = 8'hD5,
  parameter logic [7:0] PRE_OCT = 8'h55,
  parameter logic [7:0] ERR_OCT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mii_mode_i,
  input  logic        clk_en_i,
  input  logic [63:0] xd_i,
  input  logic [7:0]  xc_i,
  output logic        en_o,
  output logic        er_o,
  output logic [7:0]  d_o,
  output logic        sfd_o,
  output logic        frm_err_o
);
  import xgmii_gmii_tx_pkg::*;
  logic       ctl, nib_hi, mii, underrun, early, mode_chg;
  logic [7:0] oct;
  state_t     st, ns;
  logic [2:0] pidx, pidx_n;
  logic       en_r, er_r, hi_r, mii_r, sfd_r, fe_r;
  logic [7:0] oct_r;
  logic       en_n, er_n, sfd_n, fe_n;
  logic [7:0] oct_n;
  logic       term, bad_pre, bad_data;
  xgmii_lane_sel u_sel (
    .clk        (clk),
    .rst        (rst),
    .mii_mode_i (mii_mode_i),
    .clk_en_i   (clk_en_i),
    .xd_i       (xd_i),
    .xc_i       (xc_i),
    .ctl        (ctl),
    .oct        (oct),
    .nib_hi     (nib_hi),
    .mii        (mii),
    .underrun   (underrun),
    .early      (early),
    .mode_chg   (mode_chg)
  );
  assign term     = ctl && oct == TERM_OCT;
  assign bad_pre  = ctl || (pidx == 3'd7 ? oct != SFD_OCT : oct != PRE_FILL);
  assign bad_data = ctl && !term && oct != ERROR_OCT;
  always_comb begin
    ns     = st;
    pidx_n = pidx;
    en_n   = 1'b0;
    er_n   = 1'b0;
    oct_n  = oct;
    sfd_n  = 1'b0;
    fe_n   = early;
    if (nib_hi) begin
      en_n  = en_r;
      er_n  = er_r;
      oct_n = oct_r;
      fe_n  = 1'b0;
    end else if (mode_chg && st != S_IDLE) begin
      en_n = 1'b1;
      er_n = 1'b1;
      fe_n = 1'b1;
      ns   = S_ABORT;
    end else if (underrun) begin
      en_n = st != S_IDLE;
      er_n = st != S_IDLE;
      fe_n = st == S_PRE || st == S_DATA;
      ns   = st == S_IDLE ? S_IDLE : S_ABORT;
    end else begin
      case (st)
        S_IDLE: begin
          en_n   = ctl && oct == START_OCT;
          oct_n  = PRE_OCT;
          fe_n   = early || !ctl;
          ns     = en_n ? S_PRE : S_IDLE;
          pidx_n = 3'd1;
        end
        S_PRE: begin
          en_n   = 1'b1;
          er_n   = bad_pre;
          fe_n   = early || bad_pre;
          sfd_n  = !bad_pre && pidx == 3'd7;
          ns     = bad_pre ? S_ABORT : pidx == 3'd7 ? S_DATA : S_PRE;
          pidx_n = pidx + 3'd1;
        end
        S_DATA: begin
          en_n = !term;
          er_n = ctl && !term;
          fe_n = early || bad_data;
          ns   = bad_data ? S_ABORT : term ? S_IDLE : S_DATA;
        end
        default: begin
          en_n = !term;
          er_n = !term;
          ns   = term ? S_IDLE : S_ABORT;
        end
      endcase
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st    <= S_IDLE;
      pidx  <= 3'd0;
      en_r  <= 1'b0;
      er_r  <= 1'b0;
      oct_r <= 8'h00;
      hi_r  <= 1'b0;
      mii_r <= 1'b0;
      sfd_r <= 1'b0;
      fe_r  <= 1'b0;
    end else begin
      st    <= ns;
      pidx  <= pidx_n;
      en_r  <= en_n;
      er_r  <= er_n;
      oct_r <= er_n ? ERR_OCT : en_n ? oct_n : 8'h00;
      hi_r  <= nib_hi;
      mii_r <= mii;
      sfd_r <= sfd_n;
      fe_r  <= fe_n;
    end
  assign en_o      = en_r;
  assign er_o      = er_r;
  assign sfd_o     = sfd_r;
  assign frm_err_o = fe_r;
  assign d_o       = mii_r ? {4'h0, hi_r ? oct_r[7:4] : oct_r[3:0]} : oct_r;
endmodule

// File: tb/tb_xgmii_gmii_tx.sv
// tb_xgmii_gmii_tx: directed frames through xgmii_gmii_tx with per-frame output tallies checked against hand-computed values
module tb_xgmii_gmii_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mii_mode_i = 1'b0;
  logic        clk_en_i = 1'b0;
  logic [63:0] xd_i = '0;
  logic [7:0]  xc_i = '0;
  logic        en_o, er_o, sfd_o, frm_err_o;
  logic [7:0]  d_o;
  int n_chk = 0;
  int n_fail = 0;
  int n_en, n_er, n_sfd, n_fe, sfd_pos, er_pos, first_en, n_tick;
  logic [7:0] dq[$];
  logic [8:0] ln[$];
  always #4 clk = ~clk;
  xgmii_gmii_tx dut (
    .clk        (clk),
    .rst        (rst),
    .mii_mode_i (mii_mode_i),
    .clk_en_i   (clk_en_i),
    .xd_i       (xd_i),
    .xc_i       (xc_i),
    .en_o       (en_o),
    .er_o       (er_o),
    .d_o        (d_o),
    .sfd_o      (sfd_o),
    .frm_err_o  (frm_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pay(input int i);
    return 8'(32'hA3 + i * 13);
  endfunction
  task automatic clear();
    n_en = 0;
    n_er = 0;
    n_sfd = 0;
    n_fe = 0;
    sfd_pos = -1;
    er_pos = -1;
    first_en = -1;
    n_tick = 0;
    dq.delete();
  endtask
  task automatic tick(input logic se, input logic [63:0] d, input logic [7:0] c);
    clk_en_i = se;
    xd_i = d;
    xc_i = c;
    @(posedge clk);
    #1;
    if (en_o) begin
      dq.push_back(d_o);
      if (er_o && er_pos < 0) er_pos = n_en;
      if (first_en < 0) first_en = n_tick;
      n_en++;
    end
    n_er += int'(er_o);
    n_sfd += int'(sfd_o);
    n_fe += int'(frm_err_o);
    if (sfd_o) sfd_pos = n_en;
    n_tick++;
  endtask
  task automatic idle_words(input int per, input int n);
    for (int t = 0; t < per * n; t++) tick(t % per == 0, {8{8'h07}}, 8'hFF);
  endtask
  task automatic build(input int kind, input int idx);
    ln.delete();
    ln.push_back(9'h1FB);
    repeat (6) ln.push_back(9'h055);
    ln.push_back(9'h0D5);
    for (int i = 0; i < 60; i++)
      ln.push_back(kind == 1 && i == idx ? 9'h1FE : kind == 2 && i == idx ? 9'h107 : {1'b0, pay(i)});
    ln.push_back(9'h1FD);
    while (ln.size() % 8 != 0) ln.push_back(9'h107);
  endtask
  task automatic send(input logic mii, input int gap_w, input int rst_w);
    logic [63:0] d;
    logic [7:0]  c;
    int per;
    per = mii ? 16 : 8;
    clear();
    mii_mode_i = mii;
    for (int w = 0; w < ln.size() / 8; w++) begin
      for (int l = 0; l < 8; l++) begin
        d[8*l +: 8] = ln[8*w+l][7:0];
        c[l] = ln[8*w+l][8];
      end
      for (int t = 0; t < per; t++) begin
        if (w == rst_w && t == 3) begin
          rst = 1'b1;
          tick(1'b0, d, c);
          rst = 1'b0;
          chk("rst_mid", {20'h0, en_o, er_o, sfd_o, frm_err_o, d_o}, 32'h0);
          return;
        end
        tick(t == 0, d, c);
      end
      if (w == gap_w) repeat (3) tick(1'b0, d, c);
    end
    idle_words(per, 2);
  endtask
  initial begin
    repeat (3) tick(1'b0, {8{8'h07}}, 8'hFF);
    chk("reset_out", {20'h0, en_o, er_o, sfd_o, frm_err_o, d_o}, 32'h0);
    rst = 1'b0;
    idle_words(8, 2);
    build(0, 0);
    send(1'b0, -1, -1);
    chk("ge_en_len", n_en, 68);
    chk("ge_first_en", first_en, 0);
    chk("ge_d0", dq[0], 8'h55);
    chk("ge_d7", dq[7], 8'hD5);
    chk("ge_d8", dq[8], pay(0));
    chk("ge_d67", dq[67], pay(59));
    chk("ge_sfd_n", n_sfd, 1);
    chk("ge_sfd_pos", sfd_pos, 8);
    chk("ge_fe", n_fe, 0);
    chk("ge_er", n_er, 0);
    chk("ge_en_end", en_o, 1'b0);
    send(1'b1, -1, -1);
    chk("mii_en_len", n_en, 136);
    chk("mii_d0", dq[0], 8'h05);
    chk("mii_d1", dq[1], 8'h05);
    chk("mii_d14", dq[14], 8'h05);
    chk("mii_d15", dq[15], 8'h0D);
    chk("mii_d16", dq[16], 8'h03);
    chk("mii_d17", dq[17], 8'h0A);
    chk("mii_sfd_pos", sfd_pos, 15);
    chk("mii_sfd_n", n_sfd, 1);
    chk("mii_fe", n_fe, 0);
    build(1, 2);
    send(1'b0, -1, -1);
    chk("err_en_len", n_en, 68);
    chk("err_er_n", n_er, 1);
    chk("err_er_pos", er_pos, 10);
    chk("err_d10", dq[10], 8'h00);
    chk("err_d11", dq[11], pay(3));
    chk("err_fe", n_fe, 0);
    build(2, 20);
    send(1'b0, -1, -1);
    chk("idl_en_len", n_en, 68);
    chk("idl_er_pos", er_pos, 28);
    chk("idl_er_n", n_er, 40);
    chk("idl_fe", n_fe, 1);
    chk("idl_en_end", en_o, 1'b0);
    build(0, 0);
    send(1'b0, 3, -1);
    chk("gap_en_len", n_en, 71);
    chk("gap_er_pos", er_pos, 32);
    chk("gap_er_n", n_er, 39);
    chk("gap_fe", n_fe, 1);
    chk("gap_en_end", en_o, 1'b0);
    clear();
    tick(1'b1, {8{8'h07}}, 8'hFF);
    tick(1'b0, {8{8'h07}}, 8'hFF);
    tick(1'b0, {8{8'h07}}, 8'hFF);
    tick(1'b1, {8{8'h07}}, 8'hFF);
    repeat (7) tick(1'b0, {8{8'h07}}, 8'hFF);
    chk("early_fe", n_fe, 1);
    chk("early_en", n_en, 0);
    send(1'b0, -1, 3);
    build(0, 0);
    send(1'b0, -1, -1);
    chk("post_rst_en_len", n_en, 68);
    chk("post_rst_sfd_pos", sfd_pos, 8);
    chk("post_rst_fe", n_fe, 0);
    chk("post_rst_d8", dq[8], pay(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
